// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 scan-code receiver
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_e;

   localparam int         PS2_FRAME_BITS = 11;
   localparam logic [7:0] PS2_BREAK      = 8'hF0;
   localparam logic [7:0] PS2_EXT        = 8'hE0;

endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - 2-flop synchronizer plus FILT_LEN-sample stability filter
module ps2_sync_filter #(
   parameter int FILT_LEN = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic filt_o
);

   localparam int CW = $clog2(FILT_LEN + 1);

   logic [1:0]    sync_q;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // cnt_q holds how many consecutive samples have disagreed with the filtered level
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_q[1] != filt_q) begin
         if (cnt_q == CW'(FILT_LEN - 1)) begin
            filt_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b11;
         filt_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], raw_i};
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 device-to-host frame receiver with 4-byte scan-code history
// Optional odd-parity enforcement: PS2RX_PARITY_CHECK_EN
module ps2_scancode_rx
   import ps2_pkg::*;
#(
   parameter int FILT_LEN = 8,
   parameter int TIMEOUT  = 20000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [7:0]  code,
   output logic        code_valid,
   output logic [31:0] x,
   output logic        frame_err,
   output logic        parity_err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic          clk_filt;
   logic          clk_prev_q;
   logic [1:0]    data_sync_q;
   logic          fall;
   logic          bit_in;
   logic          parity_bad;

   ps2_state_e    state_q, state_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    code_q, code_d;
   logic [31:0]   x_q, x_d;
   logic          cv_q, cv_d;
   logic          fe_q, fe_d;
   logic          pe_q, pe_d;

   ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
      .clk_i  (clk),
      .rst_ni (reset),
      .raw_i  (ps2_clk),
      .filt_o (clk_filt)
   );

   assign fall   = clk_prev_q & ~clk_filt;
   assign bit_in = data_sync_q[1];

`ifdef PS2RX_PARITY_CHECK_EN
   logic par_q, par_d;
   // odd parity: data plus parity bit must have odd weight
   assign parity_bad = ~^{shift_q, par_q};
`else
   assign parity_bad = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      code_d   = code_q;
      x_d      = x_q;
      cv_d     = 1'b0;
      fe_d     = 1'b0;
      pe_d     = 1'b0;
      tmo_d    = (state_q == IDLE) ? '0 : tmo_q + 1'b1;
`ifdef PS2RX_PARITY_CHECK_EN
      par_d    = par_q;
`endif
      if (fall) begin
         tmo_d = '0;
         case (state_q)
            IDLE: begin
               if (!bit_in) begin
                  state_d  = DATA;
                  bitcnt_d = 3'd0;
               end else begin
                  fe_d = 1'b1;
               end
            end
            DATA: begin
               shift_d  = {bit_in, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
`ifdef PS2RX_PARITY_CHECK_EN
               par_d   = bit_in;
`endif
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               // a bad stop bit outranks a parity failure
               if (!bit_in) begin
                  fe_d = 1'b1;
               end else if (parity_bad) begin
                  pe_d = 1'b1;
               end else begin
                  code_d = shift_q;
                  x_d    = {x_q[23:0], shift_q};
                  cv_d   = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT - 1)) begin
         state_d = IDLE;
         tmo_d   = '0;
         fe_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_prev_q  <= 1'b1;
         data_sync_q <= 2'b11;
         state_q     <= IDLE;
         bitcnt_q    <= 3'd0;
         shift_q     <= 8'h00;
         tmo_q       <= '0;
         code_q      <= 8'h00;
         x_q         <= 32'h0;
         cv_q        <= 1'b0;
         fe_q        <= 1'b0;
         pe_q        <= 1'b0;
`ifdef PS2RX_PARITY_CHECK_EN
         par_q       <= 1'b0;
`endif
      end else begin
         clk_prev_q  <= clk_filt;
         data_sync_q <= {data_sync_q[0], ps2_data};
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         shift_q     <= shift_d;
         tmo_q       <= tmo_d;
         code_q      <= code_d;
         x_q         <= x_d;
         cv_q        <= cv_d;
         fe_q        <= fe_d;
         pe_q        <= pe_d;
`ifdef PS2RX_PARITY_CHECK_EN
         par_q       <= par_d;
`endif
      end
   end

   assign code       = code_q;
   assign x          = x_q;
   assign code_valid = cv_q;
   assign frame_err  = fe_q;
   assign parity_err = pe_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - directed self-checking bench for ps2_scancode_rx
module tb_ps2_scancode_rx;
   import ps2_pkg::*;

   localparam int FILT_LEN = 8;
   localparam int TIMEOUT  = 20000;
   localparam int HALF     = 40;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ps2_clk;
   logic        ps2_data;
   logic [7:0]  code;
   logic        code_valid;
   logic [31:0] x;
   logic        frame_err;
   logic        parity_err;

   int tests = 0;
   int fails = 0;
   int cv_cnt = 0;
   int fe_cnt = 0;
   int pe_cnt = 0;
   int multi_cnt = 0;
   int cv_base;
   int fe_base;
   logic glitch = 1'b0;

   ps2_scancode_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .code       (code),
      .code_valid (code_valid),
      .x          (x),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (code_valid) cv_cnt++;
      if (frame_err)  fe_cnt++;
      if (parity_err) pe_cnt++;
      if (int'(code_valid) + int'(frame_err) + int'(parity_err) > 1) multi_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      if (glitch) begin
         repeat (10) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (FILT_LEN - 1) @(negedge clk);
         ps2_clk = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit((~^d) ^ par_flip);
      ps2_bit(stop);
      ps2_data = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      rst_n    = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_code", {24'h0, code}, 32'h0);
      check("rst_x", x, 32'h0);
      check("rst_cv", {31'h0, code_valid}, 32'h0);
      check("rst_fe", {31'h0, frame_err}, 32'h0);
      check("rst_pe", {31'h0, parity_err}, 32'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // single good frame
      send_frame(8'h45, 1'b0, 1'b1);
      check("f45_code", {24'h0, code}, 32'h45);
      check("f45_x", x, 32'h00000045);
      check("f45_cv", cv_cnt, 1);

      // back-to-back frames, history wraps
      send_frame(8'h16, 1'b0, 1'b1);
      send_frame(8'h1E, 1'b0, 1'b1);
      send_frame(8'h26, 1'b0, 1'b1);
      send_frame(8'h25, 1'b0, 1'b1);
      send_frame(8'h2E, 1'b0, 1'b1);
      check("seq_x", x, 32'h1E26252E);
      check("seq_code", {24'h0, code}, 32'h2E);
      check("seq_cv", cv_cnt, 6);

      // bad stop bit
      send_frame(8'h45, 1'b0, 1'b0);
      check("stop_fe", fe_cnt, 1);
      check("stop_x", x, 32'h1E26252E);
      check("stop_code", {24'h0, code}, 32'h2E);
      check("stop_cv", cv_cnt, 6);
      send_frame(8'h1E, 1'b0, 1'b1);
      check("after_stop_x", x, 32'h26252E1E);
      check("after_stop_cv", cv_cnt, 7);

      // wrong parity
      send_frame(8'h45, 1'b1, 1'b1);
`ifdef PS2RX_PARITY_CHECK_EN
      check("par_pe", pe_cnt, 1);
      check("par_x", x, 32'h26252E1E);
      check("par_cv", cv_cnt, 7);
`else
      check("par_pe", pe_cnt, 0);
      check("par_x", x, 32'h252E1E45);
      check("par_cv", cv_cnt, 8);
`endif

      // stall after four data bits
      cv_base = cv_cnt;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      ps2_data = 1'b1;
      repeat (TIMEOUT + 200) @(negedge clk);
      check("tmo_fe", fe_cnt, 2);
      check("tmo_cv", cv_cnt, cv_base);
      send_frame(PS2_BREAK, 1'b0, 1'b1);
      check("brk_code", {24'h0, code}, 32'hF0);
`ifdef PS2RX_PARITY_CHECK_EN
      check("brk_x", x, 32'h252E1EF0);
`else
      check("brk_x", x, 32'h2E1E45F0);
`endif
      check("tmo_fe_once", fe_cnt, 2);

      // glitchy clock then reset mid-frame
      glitch  = 1'b1;
      fe_base = fe_cnt;
      cv_base = cv_cnt;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_rst_code", {24'h0, code}, 32'h0);
      check("mid_rst_x", x, 32'h0);
      check("mid_rst_cv", {31'h0, code_valid}, 32'h0);
      check("mid_rst_fe", {31'h0, frame_err}, 32'h0);
      check("mid_rst_pe", {31'h0, parity_err}, 32'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      send_frame(8'h1C, 1'b0, 1'b1);
      check("glitch_code", {24'h0, code}, 32'h1C);
      check("glitch_x", x, 32'h0000001C);
      check("glitch_cv", cv_cnt, cv_base + 1);
      check("glitch_fe", fe_cnt, fe_base);
      glitch = 1'b0;

      check("one_hot_pulses", multi_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
